// File: rtl/sample_stream_arbiter.sv
// Round-robin arbiter sharing one sample stream among N_SRC sources.
// A grant is held for a whole frame of FRAME_LEN beats so channel order never interleaves.
module sample_stream_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DWIDTH    = 24,
    parameter int FRAME_LEN = 2,
    localparam int SRC_W    = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_SRC-1:0]          src_mask,
    input  logic [N_SRC*DWIDTH-1:0]   s_data,
    input  logic [N_SRC-1:0]          s_valid,
    output logic [N_SRC-1:0]          s_ready,
    output logic [DWIDTH-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SRC_W-1:0]          m_src,
    output logic                      m_first,
    output logic                      busy,
    output logic [31:0]               frame_count
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_next;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_grant;
    logic [BW-1:0]    beat_cnt;

    logic [N_SRC-1:0] req;
    logic             pick_found;
    logic [SRC_W-1:0] pick;
    logic [SRC_W:0]   rr_sum;
    logic [SRC_W-1:0] rr_idx;
    logic             active;
    logic             handshake;
    logic             frame_done;

    assign req = s_valid & src_mask;

    // Search last_grant+1, last_grant+2, ... modulo N_SRC; first requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
        pick_found = 1'b0;
        pick       = '0;
        rr_sum     = '0;
        rr_idx     = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            rr_sum = {1'b0, last_grant} + (SRC_W+1)'(i);
            if (rr_sum >= (SRC_W+1)'(N_SRC)) begin
                rr_sum = rr_sum - (SRC_W+1)'(N_SRC);
            end
            rr_idx = rr_sum[SRC_W-1:0];
            if (!pick_found && req[rr_idx]) begin
                pick_found = 1'b1;
                pick       = rr_idx;
            end
        end
    end

    // Gating with reset drops the frame in the very cycle reset is seen.
    assign active     = (state == GRANT) && !reset;
    assign handshake  = m_valid && m_ready;
    assign frame_done = handshake && (beat_cnt == BW'(FRAME_LEN - 1));

    always_comb begin
        state_next = state;
        s_ready    = '0;
        m_valid    = 1'b0;
        m_first    = 1'b0;
        busy       = 1'b0;
        m_data     = s_data[int'(grant)*DWIDTH +: DWIDTH];
        m_src      = grant;
        case (state)
            IDLE: begin
                if (enable && pick_found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (active) begin
                    m_valid        = s_valid[grant];
                    s_ready[grant] = m_ready;
                    busy           = 1'b1;
                    m_first        = (beat_cnt == '0);
                end
                if (frame_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            last_grant  <= SRC_W'(N_SRC - 1);
            beat_cnt    <= '0;
            frame_count <= '0;
        end else begin
            if (state == IDLE) begin
                if (enable && pick_found) begin
                    grant    <= pick;
                    beat_cnt <= '0;
                end
            end else if (handshake) begin
                if (frame_done) begin
                    beat_cnt    <= '0;
                    last_grant  <= grant;
                    frame_count <= frame_count + 32'd1;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Scoreboard bench for sample_stream_arbiter: directed scenarios push expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_sample_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int FL = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    src_mask;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic [1:0]      m_src;
    logic            m_first;
    logic            busy;
    logic [31:0]     frame_count;

    sample_stream_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable), .src_mask(src_mask),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_src(m_src), .m_first(m_first), .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    src;
        logic          first;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Source model: source i presents base[i]+cnt[i] while rem[i] beats remain.
    int          rem[N];
    int          cnt[N];
    int          base[N];
    int          exp_cnt[N];
    logic [N-1:0] fire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic update_src();
        for (int i = 0; i < N; i++) begin
            s_valid[i]          = (rem[i] != 0);
            s_data[i*DW +: DW]  = DW'(base[i] + cnt[i]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        fire = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                cnt[i]++;
                rem[i]--;
            end
        end
        update_src();
    endtask

    task automatic push_beat(input int src, input logic first);
        beat_t b;
        b.data  = DW'(base[src] + exp_cnt[src]);
        b.src   = 2'(src);
        b.first = first;
        exp_q.push_back(b);
        exp_cnt[src]++;
    endtask

    task automatic push_frame(input int src);
        for (int b = 0; b < FL; b++) push_beat(src, b == 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic start_scenario(input int rem_all, input int base_step);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i]     = 0;
            cnt[i]     = 0;
            exp_cnt[i] = 0;
            base[i]    = base_step * i;
        end
        enable   = 1'b1;
        src_mask = '1;
        m_ready  = 1'b1;
        update_src();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = rem_all;
        update_src();
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            check("sb_expected_beat", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                check("sb_data", m_data, e.data);
                check("sb_src", m_src, e.src);
                check("sb_first", m_first, e.first);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        src_mask = '1;
        m_ready  = 1'b1;
        s_data   = '0;
        s_valid  = '0;
        fire     = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 4; cnt[i] = 0; exp_cnt[i] = 0; base[i] = 'h100 * i;
        end
        update_src();

        // Long reset with every source requesting.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_frame_count", frame_count, 0);
        end
        check("rst_busy", busy, 0);
        check("rst_m_first", m_first, 0);
        check("rst_m_src", m_src, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // All four valid: strict 0,1,2,3 rotation, two beats each.
        for (int k = 0; k < 8; k++) push_frame(k % N);
        step();
        check("rr_first_grant_src", m_src, 0);
        check("rr_first_grant_busy", busy, 1);
        drain("rr_drain", 100);
        step();
        check("rr_frame_count", frame_count, 8);

        // Single source with continuous counting data.
        start_scenario(0, 0);
        rem[1] = 200;
        update_src();
        for (int k = 0; k < 100; k++) push_frame(1);
        for (int c = 0; c < 300; c++) step();
        check("single_frame_count", frame_count, 100);
        check("single_drain", exp_q.size(), 0);

        // Backpressure mid-frame with sources 0 and 2 requesting.
        start_scenario(0, 'h100);
        rem[0] = 2;
        rem[2] = 2;
        update_src();
        push_frame(0);
        push_frame(2);
        step();
        check("bp_s_ready_g0", s_ready, 4'b0001);
        step();
        m_ready = 1'b0;
        #1;
        check("bp_stall_data0", m_data, 'h001);
        check("bp_stall_valid", m_valid, 1);
        check("bp_stall_ready", s_ready, 0);
        step();
        check("bp_stall_data1", m_data, 'h001);
        check("bp_stall_src", m_src, 0);
        check("bp_s_ready2", s_ready[2], 0);
        step();
        m_ready = 1'b1;
        drain("bp_drain", 50);
        step();
        check("bp_frame_count", frame_count, 2);

        // Mask and enable changes while src 2 holds the grant.
        start_scenario(100, 'h100);
        push_frame(0); push_frame(1); push_frame(2); push_frame(3);
        push_frame(0); push_frame(1); push_frame(3); push_frame(0);
        for (int c = 0; c < 8; c++) step();
        check("mask_src2_granted", m_src, 2);
        check("mask_src2_mid", m_first, 0);
        src_mask[2] = 1'b0;
        for (int c = 0; c < 14; c++) step();
        check("en_last_src", m_src, 0);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("en_drain", exp_q.size(), 0);
        check("en_busy", busy, 0);
        check("en_m_valid", m_valid, 0);
        check("en_s_ready", s_ready, 0);
        check("en_frame_count", frame_count, 8);

        // Reset one beat into src 3's frame.
        start_scenario(100, 'h100);
        push_frame(0); push_frame(1); push_frame(2);
        push_beat(3, 1'b1);
        push_frame(0);
        for (int c = 0; c < 11; c++) step();
        check("mrst_src3_mid", m_src, 3);
        reset = 1'b1;
        #1;
        check("mrst_gate_valid", m_valid, 0);
        step();
        reset = 1'b0;
        check("mrst_frame_count0", frame_count, 0);
        check("mrst_busy0", busy, 0);
        step();
        check("mrst_regrant_src", m_src, 0);
        enable = 1'b0;
        drain("mrst_drain", 20);
        step();
        step();
        check("mrst_frame_count1", frame_count, 1);
        check("mrst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_stream_arbiter.md
Name: sample_stream_arbiter

Overview:
- Round-robin arbiter that shares the single `sample_buffer` input stream among N_SRC audio sources (codec ADC, tone generator, DMA playback, ...).
- Grants one source for a whole frame of FRAME_LEN beats (default 2 = stereo L/R pair), so channel ordering is never interleaved between sources.
- Sits directly upstream of `sample_buffer`; `m_*` drives the buffer's `din`.

Parameters:
- N_SRC, 4, number of requesting sources (>=2).
- DWIDTH, 24, sample width in bits.
- FRAME_LEN, 2, beats per granted frame (>=1).
- SRC_W, $clog2(N_SRC), width of source index (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = arbitration allowed; 0 = finish current frame, then stop granting.
- src_mask  in  N_SRC  per-source enable; masked sources are never granted.
- s_data  in  N_SRC*DWIDTH  source samples; source i occupies bits [i*DWIDTH +: DWIDTH].
- s_valid  in  N_SRC  source valid.
- s_ready  out  N_SRC  source ready.
- m_data  out  DWIDTH  sample to sample_buffer.
- m_valid  out  1  output valid.
- m_ready  in  1  sample_buffer ready.
- m_src  out  SRC_W  index of the currently granted source.
- m_first  out  1  high on the first beat of a frame.
- busy  out  1  high while a grant is held.
- frame_count  out  32  completed frames since reset; wraps at 2^32.

Behaviour:
- Reset values: m_valid=0, s_ready=0, m_src=0, m_first=0, busy=0, frame_count=0.
- Internal reset values: state=IDLE, beat_cnt=0, last_grant=N_SRC-1, so source 0 has top priority after reset.
- Reset mid-frame: the frame is abandoned immediately, with no further handshakes.
- FSM states: IDLE, GRANT.
- IDLE:
  - req = s_valid & src_mask.
  - If enable && |req: choose the first set req bit searching last_grant+1, last_grant+2, ... modulo N_SRC.
  - Register the choice into grant/m_src, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
  - All outputs are idle: m_valid=0, s_ready=0, busy=0.
- GRANT (datapath combinational from the registered grant):
  - m_data = s_data[grant]; m_valid = s_valid[grant].
  - s_ready[grant] = m_ready; all other s_ready = 0.
  - busy=1; m_first = (beat_cnt==0).
- Handshake is m_valid && m_ready. On each handshake beat_cnt increments.
- On the handshake with beat_cnt==FRAME_LEN-1:
  - last_grant=grant, frame_count++, beat_cnt=0.
  - Next state IDLE.
- Grant is held until the frame completes, regardless of:
  - source valid dropping mid-frame (bubbles allowed);
  - m_ready stalls;
  - src_mask or enable changes.
- src_mask and enable are sampled only in IDLE.
- Latency: decision takes 1 IDLE cycle, so the first beat can transfer in the cycle after the request is seen.
- Throughput: max FRAME_LEN beats per FRAME_LEN+1 cycles. This is adequate, since sample rate << clk rate.
- No combinational path from s_valid to s_ready. The only paths are m_ready -> s_ready and s_data/s_valid -> m_*.
- FRAME_LEN=1: every beat is a frame and m_first=1 on every beat.
- All req bits masked, or enable=0: remain in IDLE indefinitely, with no ready asserted to any source.
- Single requester: it is re-granted after each IDLE cycle.

Test Plan:
- Reset: hold reset 500 cycles with all s_valid=1 -> s_ready=0, m_valid=0, frame_count=0 throughout. On release, first grant is m_src=0.
- Single source, continuous counting data:
  - Setup: src 1 valid with data 0,1,2..., m_ready=1, src_mask=4'b1111.
  - m_data sequence is 0,1,2,... with no gaps, all with m_src=1.
  - m_first pattern is 1,0 with 1 IDLE cycle between frames.
  - frame_count=100 after 300 cycles.
- All four sources valid, each sending base 0x100*i + n:
  - Grant order is 0,1,2,3,0,...
  - Each frame is 2 consecutive beats from one source, e.g. 0x000,0x001,0x100,0x101,0x200,...
- Backpressure: toggle m_ready 1,0,0,1 starting mid-frame with src 0 and src 2 valid.
  - m_data stays stable while stalled.
  - The second beat still comes from src 0; src 2 is granted next.
  - s_ready[2]=0 until its grant.
- Mask/enable changes while src 2 is granted after beat 0:
  - Clear src_mask[2] -> the frame completes (2 beats); src 2 is then skipped (order 3,0,1,3...).
  - Drop enable -> the current frame completes, then busy=0 and no new grant.
- Reset mid-frame: assert reset for 1 cycle after the first beat of src 3's frame.
  - Next beat comes from src 0 with m_first=1.
  - frame_count=0 afterward; no orphan second beat from src 3.
